// File: rtl/sample_delay_buffer.sv
// Circular sample delay line: pairs each input sample with the one stored buffer_depth
// samples earlier, hands both to an external operator, writes back and emits its result.
module sample_delay_buffer #(
    parameter int sample_width = 16,
    parameter int buffer_depth = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [sample_width-1:0] i_audio,
    output logic                    o_valid_operator,
    input  logic                    o_ready_operator,
    output logic [sample_width-1:0] o_current,
    output logic [sample_width-1:0] o_buffer,
    input  logic                    i_valid_result,
    output logic                    i_ready_result,
    input  logic [sample_width-1:0] i_result,
    input  logic [sample_width-1:0] i_buffer,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [sample_width-1:0] o_audio
);

    localparam int ptr_w = (buffer_depth > 1) ? $clog2(buffer_depth) : 1;
    localparam logic [ptr_w-1:0] last_idx = ptr_w'(buffer_depth - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_OPER,
        S_RESULT,
        S_OUT
    } state_t;

    state_t state, next_state;

    logic [ptr_w-1:0]        ptr;
    logic [ptr_w-1:0]        clr_idx;
    logic [sample_width-1:0] mem [buffer_depth];
    logic [sample_width-1:0] rd_data;

    logic                    in_xfer, op_xfer, res_xfer, out_xfer;
    logic                    mem_we;
    logic [ptr_w-1:0]        mem_addr;
    logic [sample_width-1:0] mem_wdata;

    // Handshake flags are pure state decodes, so at most one is ever high.
    assign i_ready          = (state == S_IDLE);
    assign o_valid_operator = (state == S_OPER);
    assign i_ready_result   = (state == S_RESULT);
    assign o_valid          = (state == S_OUT);

    assign in_xfer  = i_valid & i_ready;
    assign op_xfer  = o_valid_operator & o_ready_operator;
    assign res_xfer = i_valid_result & i_ready_result;
    assign out_xfer = o_valid & o_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_CLEAR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_CLEAR:  if (clr_idx == last_idx) next_state = S_IDLE;
            S_IDLE:   if (in_xfer) next_state = S_READ;
            S_READ:   next_state = S_OPER;
            S_OPER:   if (op_xfer) next_state = S_RESULT;
            S_RESULT: if (res_xfer) next_state = S_OUT;
            S_OUT:    if (out_xfer) next_state = S_IDLE;
            default:  next_state = S_CLEAR;
        endcase
    end

    // Single write port shared between the clear sweep and the operator write-back.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = ptr;
        mem_wdata = '0;
        if (state == S_CLEAR) begin
            mem_we   = 1'b1;
            mem_addr = clr_idx;
        end else if (res_xfer) begin
            mem_we    = 1'b1;
            mem_wdata = i_buffer;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (in_xfer) begin
            rd_data <= mem[ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            clr_idx   <= '0;
            o_current <= '0;
            o_buffer  <= '0;
            o_audio   <= '0;
        end else begin
            if (state == S_CLEAR) begin
                clr_idx <= (clr_idx == last_idx) ? '0 : clr_idx + ptr_w'(1);
            end
            if (in_xfer) begin
                o_current <= i_audio;
            end
            if (state == S_READ) begin
                o_buffer <= rd_data;
            end
            if (res_xfer) begin
                ptr     <= (ptr == last_idx) ? '0 : ptr + ptr_w'(1);
                o_audio <= i_result;
            end
        end
    end

endmodule

// File: tb/tb_sample_delay_buffer.sv
// Scoreboard bench for sample_delay_buffer: emulates the operator (result = current + buffer,
// write-back = current) and the downstream sink, with a reference model of the delay line.
module tb_sample_delay_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [15:0] i_audio = '0;
    logic        o_valid_operator;
    logic        o_ready_operator = 1'b0;
    logic [15:0] o_current;
    logic [15:0] o_buffer;
    logic        i_valid_result = 1'b0;
    logic        i_ready_result;
    logic [15:0] i_result = '0;
    logic [15:0] i_buffer = '0;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic [15:0] o_audio;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [4];
    int          mptr;
    logic [15:0] sb [$];

    sample_delay_buffer #(.sample_width(16), .buffer_depth(4)) dut (
        .clk(clk),
        .reset(reset),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_audio(i_audio),
        .o_valid_operator(o_valid_operator),
        .o_ready_operator(o_ready_operator),
        .o_current(o_current),
        .o_buffer(o_buffer),
        .i_valid_result(i_valid_result),
        .i_ready_result(i_ready_result),
        .i_result(i_result),
        .i_buffer(i_buffer),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_audio(o_audio)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model_mem[i] = '0;
        mptr = 0;
        sb.delete();
    endtask

    // Releases reset and checks that i_ready appears exactly 4 cycles later.
    task automatic release_and_wait_clear();
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (i_ready !== (k == 4)) begin
                errors++;
                $display("[TB] FAIL clear_timing cycle %0d i_ready=%b required %b", k, i_ready, (k == 4));
            end
        end
        model_clear();
    endtask

    task automatic run_sample(input logic [15:0] audio, input int op_wait, input int res_wait,
                              input int out_wait, output logic [15:0] got_audio,
                              output logic [15:0] got_buf);
        logic [15:0] exp_buf;
        logic [15:0] exp_q;
        int n;
        n = 0;
        while (i_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (i_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_wait i_ready=%b required 1", i_ready);
        end
        exp_buf = model_mem[mptr];
        sb.push_back(audio + exp_buf);
        i_valid = 1'b1;
        i_audio = audio;
        @(negedge clk);
        i_valid = 1'b0;
        checks++;
        if (o_valid_operator !== 1'b0 || i_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_cycle o_valid_operator=%b i_ready=%b required 0 0", o_valid_operator, i_ready);
        end
        @(negedge clk);
        checks++;
        if (o_valid_operator !== 1'b1 || o_current !== audio || o_buffer !== exp_buf) begin
            errors++;
            $display("[TB] FAIL operands valid=%b cur=%h buf=%h required 1 %h %h", o_valid_operator, o_current, o_buffer, audio, exp_buf);
        end
        got_buf = o_buffer;
        // Junk on idle channels while the operator stalls must be ignored.
        for (int i = 0; i < op_wait; i++) begin
            i_valid = 1'b1;
            i_audio = 16'hbeef;
            i_valid_result = 1'b1;
            i_result = 16'hdead;
            @(negedge clk);
            checks++;
            if (o_valid_operator !== 1'b1 || i_ready !== 1'b0 || i_ready_result !== 1'b0 ||
                o_current !== audio || o_buffer !== exp_buf) begin
                errors++;
                $display("[TB] FAIL oper_hold valid=%b rdy=%b rrdy=%b cur=%h buf=%h required 1 0 0 %h %h", o_valid_operator, i_ready, i_ready_result, o_current, o_buffer, audio, exp_buf);
            end
        end
        i_valid = 1'b0;
        i_valid_result = 1'b0;
        o_ready_operator = 1'b1;
        @(negedge clk);
        o_ready_operator = 1'b0;
        checks++;
        if (i_ready_result !== 1'b1 || o_valid_operator !== 1'b0) begin
            errors++;
            $display("[TB] FAIL oper_xfer i_ready_result=%b o_valid_operator=%b required 1 0", i_ready_result, o_valid_operator);
        end
        for (int i = 0; i < res_wait; i++) begin
            @(negedge clk);
            checks++;
            if (i_ready_result !== 1'b1 || o_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL result_wait i_ready_result=%b o_valid=%b required 1 0", i_ready_result, o_valid);
            end
        end
        i_valid_result = 1'b1;
        i_result = audio + exp_buf;
        i_buffer = audio;
        @(negedge clk);
        i_valid_result = 1'b0;
        model_mem[mptr] = audio;
        mptr = (mptr == 3) ? 0 : mptr + 1;
        checks++;
        if (o_valid !== 1'b1 || i_ready_result !== 1'b0) begin
            errors++;
            $display("[TB] FAIL result_xfer o_valid=%b i_ready_result=%b required 1 0", o_valid, i_ready_result);
        end
        for (int i = 0; i < out_wait; i++) begin
            i_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b1 || i_ready !== 1'b0 || o_audio !== sb[0]) begin
                errors++;
                $display("[TB] FAIL out_hold o_valid=%b i_ready=%b audio=%h required 1 0 %h", o_valid, i_ready, o_audio, sb[0]);
            end
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        exp_q = sb.pop_front();
        got_audio = o_audio;
        checks++;
        if (o_audio !== exp_q) begin
            errors++;
            $display("[TB] FAIL output_data o_audio=%h required %h", o_audio, exp_q);
        end
        @(negedge clk);
        o_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL out_xfer o_valid=%b i_ready=%b required 0 1", o_valid, i_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (i_ready !== 1'b0 || o_valid_operator !== 1'b0 || i_ready_result !== 1'b0 || o_valid !== 1'b0 ||
            o_current !== 16'h0 || o_buffer !== 16'h0 || o_audio !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_values rdy=%b vop=%b rrdy=%b ov=%b cur=%h buf=%h aud=%h required all 0", i_ready, o_valid_operator, i_ready_result, o_valid, o_current, o_buffer, o_audio);
        end
        release_and_wait_clear();
    endtask

    task automatic run_table(input int op_wait, input int res_wait, input string tag);
        logic [15:0] ins  [12] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h0001, 16'h0002,
                                   16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
        logic [15:0] outs [12] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h1001, 16'h2002,
                                   16'h3003, 16'h4004, 16'h0006, 16'h0008, 16'h000A, 16'h000C};
        logic [15:0] got, gbuf;
        for (int i = 0; i < 12; i++) begin
            run_sample(ins[i], op_wait, res_wait, 0, got, gbuf);
            checks++;
            if (got !== outs[i]) begin
                errors++;
                $display("[TB] FAIL %s sample %0d o_audio=%h required %h", tag, i, got, outs[i]);
            end
        end
    endtask

    task automatic test_basic_flow();
        run_table(0, 0, "basic_flow");
    endtask

    task automatic test_operator_latency();
        reset = 1'b1;
        @(negedge clk);
        release_and_wait_clear();
        run_table(3, 2, "operator_latency");
    endtask

    task automatic test_backpressure();
        logic [15:0] got, gbuf;
        run_sample(16'h0a0a, 0, 0, 5, got, gbuf);
        run_sample(16'h0b0b, 1, 1, 5, got, gbuf);
    endtask

    task automatic test_wrap();
        logic [15:0] got, gbuf;
        reset = 1'b1;
        @(negedge clk);
        release_and_wait_clear();
        for (int i = 1; i <= 9; i++) begin
            run_sample(16'(i * 16'h0111), 0, 0, 0, got, gbuf);
        end
        checks++;
        if (gbuf !== 16'h0555) begin
            errors++;
            $display("[TB] FAIL wrap sample9 o_buffer=%h required 0555", gbuf);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] got, gbuf;
        for (int i = 0; i < 4; i++) run_sample(16'h7000 + 16'(i), 0, 0, 0, got, gbuf);
        i_valid = 1'b1;
        i_audio = 16'h1234;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (o_valid_operator !== 1'b0 || i_ready !== 1'b0 || o_current !== 16'h0 || o_buffer !== 16'h0) begin
            errors++;
            $display("[TB] FAIL mid_reset vop=%b rdy=%b cur=%h buf=%h required 0 0 0000 0000", o_valid_operator, i_ready, o_current, o_buffer);
        end
        release_and_wait_clear();
        run_sample(16'h5555, 0, 0, 0, got, gbuf);
        checks++;
        if (gbuf !== 16'h0000 || got !== 16'h5555) begin
            errors++;
            $display("[TB] FAIL mid_reset_after buf=%h audio=%h required 0000 5555", gbuf, got);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_flow();
        test_operator_latency();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_delay_buffer.md
# sample_delay_buffer

Circular sample delay line for the audio echo path. Each accepted input sample goes to an external operator block together with the sample stored `buffer_depth` samples earlier. The operator returns a result sample plus a write-back value. The write-back value replaces the old buffer entry, and the result is emitted downstream. Exactly one sample is in flight at a time, and every interface uses a valid/ready handshake.

## Interface
Parameters:
- `sample_width`, 16: bit width of every audio/data bus.
- `buffer_depth`, 4: number of buffer entries, which is the delay in samples. Must be ≥1; need not be a power of two.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  input sample valid.
- `i_ready`  out  1  block can accept an input sample.
- `i_audio`  in  `sample_width`  input sample.
- `o_valid_operator`  out  1  operand pair valid to operator.
- `o_ready_operator`  in  1  operator accepts operands.
- `o_current`  out  `sample_width`  the accepted input sample.
- `o_buffer`  out  `sample_width`  delayed sample read from buffer.
- `i_valid_result`  in  1  operator result valid.
- `i_ready_result`  out  1  block accepts operator result.
- `i_result`  in  `sample_width`  sample to emit downstream.
- `i_buffer`  in  `sample_width`  value written back into the current buffer slot.
- `o_valid`  out  1  output sample valid.
- `o_ready`  in  1  downstream accepts output.
- `o_audio`  out  `sample_width`  output sample.

## Operation
- A transfer on any channel occurs on a rising edge where valid and ready are both high.
- Buffer: `buffer_depth` × `sample_width` storage (synchronous-read RAM), plus a write pointer `ptr` running from 0 to `buffer_depth`-1.
- No arithmetic in this block. All data passes through at full width, unmodified.
- State machine (states and exit conditions):
  - CLEAR: writes 0 to every entry, one per cycle, for `buffer_depth` cycles, then goes to IDLE.
  - IDLE: `i_ready`=1. On input transfer, captures `i_audio` into `o_current`, issues a read of mem[`ptr`], and goes to READ.
  - READ: one cycle. Loads `o_buffer` with mem[`ptr`], sets `o_valid_operator`=1, and goes to OPER.
  - OPER: holds `o_current`/`o_buffer` stable. On operator transfer, clears `o_valid_operator`, sets `i_ready_result`=1, and goes to RESULT.
  - RESULT: on result transfer:
    - writes mem[`ptr`] ← `i_buffer`;
    - sets `ptr` ← (`ptr`==`buffer_depth`-1) ? 0 : `ptr`+1;
    - sets `o_audio` ← `i_result` and `o_valid`=1;
    - clears `i_ready_result` and goes to OUT.
  - OUT: holds `o_audio`. On output transfer, clears `o_valid`, sets `i_ready`=1, and goes to IDLE.
- Handshake rules:
  - At most one of `i_ready`, `o_valid_operator`, `i_ready_result`, `o_valid` is high at any time.
  - Once a valid is asserted it stays high, with its data stable, until the transfer occurs.
  - Inputs on inactive channels are ignored.
- Pointer wrap: the slot read for sample n is the slot written by sample n−`buffer_depth`. After CLEAR, the first `buffer_depth` samples read 0.
- `o_audio` and `o_current` keep their last value after a transfer until they are overwritten.

## Timing
- Reset, sampled on a clock edge, takes effect at that edge. Resulting values:
  - `i_ready`, `o_valid_operator`, `i_ready_result`, `o_valid` = 0.
  - `o_current`, `o_buffer`, `o_audio` = 0.
  - `ptr`=0; state = CLEAR.
- Reset asserted mid-operation aborts the sample in flight and discards it; the buffer is re-cleared.
- `i_ready` rises `buffer_depth` cycles after reset is released.
- Latency: input transfer at edge E → `o_valid_operator` high after E+1.
- Operator transfer at edge K → `i_ready_result` high after K.
- Result transfer at M → `o_valid` high after M, with the buffer write committed at M.
- Output transfer at N → `i_ready` high after N.
- Minimum sample period is 5 cycles (input, read, operator, result, output), reached when every partner is always ready/valid.
- A result transfer in the same cycle as `o_valid_operator` is impossible by construction. Back-to-back samples require re-entering IDLE.

## Test plan
- Reset: hold `reset` 2 cycles, then release → all valids and readies 0, `i_ready` rises after 4 cycles (`buffer_depth`=4), all data outputs 0.
- Basic flow, `buffer_depth`=4: operator returns `i_result`=`o_current`+`o_buffer` and `i_buffer`=`o_current`, `o_ready`=1; inputs 1000,2000,3000,4000,0001…0008 (hex) → outputs 1000,2000,3000,4000,1001,2002,3003,4004,0006,0008,000A,000C.
- Operator latency: operator holds `o_ready_operator`=0 for 3 cycles and delays `i_valid_result` 2 cycles → `o_current`/`o_buffer` stay stable and `i_ready`=0 throughout; outputs unchanged versus the basic flow.
- Output backpressure: `o_ready`=0 for 5 cycles while `o_valid`=1 → `o_audio` held, `i_ready` stays 0, no input accepted; the transfer completes when `o_ready` rises.
- Wrap-around: 9 inputs with write-back = `o_current` → sample 9 reads sample 5's value (slot 0 reused twice).
- Mid-operation reset: assert reset while in OPER → valids drop, CLEAR reruns, the next sample reads `o_buffer`=0.
